// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback requesters,
// with a registered write stage and decode hazard lookup. Optional: WB_ZERO_SQUASH_EN.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [AW*NREQ-1:0]   req_addr,
   input  logic [DW*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rf_wen,
   output logic [AW-1:0]        rf_wa,
   output logic [DW-1:0]        rf_wd,
   input  logic [AW-1:0]        hz_raA,
   input  logic [AW-1:0]        hz_raB,
   output logic                 hz_hitA,
   output logic                 hz_hitB,
   output logic [2:0]           grant_id
);

   logic [2:0]      rr_ptr;
   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] cand;
   logic            found;
   logic            commit;
   logic [2:0]      sel_id;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // Rotating priority: requesters at or above rr_ptr win first, else wrap to the lowest valid.
   always_comb begin
      upper = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         upper[i] = req_valid[i] && (i >= 32'(rr_ptr));
      end
      cand = (|upper) ? upper : req_valid;

      req_ready = '0;
      found     = 1'b0;
      sel_id    = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (cand[i] && !found) begin
            found        = 1'b1;
            req_ready[i] = 1'b1;
            sel_id       = 3'(i);
            sel_addr     = req_addr[AW*i +: AW];
            sel_data     = req_data[DW*i +: DW];
         end
      end
   end

`ifdef WB_ZERO_SQUASH_EN
   assign commit = found && (sel_addr != '0);
`else
   assign commit = found;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rf_wen   <= 1'b0;
         rf_wa    <= '0;
         rf_wd    <= '0;
         rr_ptr   <= '0;
         grant_id <= '0;
      end else begin
         rf_wen <= commit;
         if (found) begin
            grant_id <= sel_id;
            rr_ptr   <= (sel_id == 3'(NREQ-1)) ? 3'd0 : sel_id + 3'd1;
         end
         if (commit) begin
            rf_wa <= sel_addr;
            rf_wd <= sel_data;
         end
      end
   end

   always_comb begin
      hz_hitA = rf_wen && (rf_wa == hz_raA);
      hz_hitB = rf_wen && (rf_wa == hz_raB);
      for (int unsigned i = 0; i < NREQ; i++) begin
         hz_hitA = hz_hitA | (req_valid[i] && (req_addr[AW*i +: AW] == hz_raA));
         hz_hitB = hz_hitB | (req_valid[i] && (req_addr[AW*i +: AW] == hz_raB));
      end
`ifdef WB_ZERO_SQUASH_EN
      if (hz_raA == '0) hz_hitA = 1'b0;
      if (hz_raB == '0) hz_hitB = 1'b0;
`endif
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + random bench for regfile_wb_arbiter against a modular-scan reference model
// and a shadow regfile; honours WB_ZERO_SQUASH_EN when defined.
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef WB_ZERO_SQUASH_EN
   localparam bit SQUASH = 1'b1;
`else
   localparam bit SQUASH = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [AW*N-1:0]   req_addr;
   logic [DW*N-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              rf_wen;
   logic [AW-1:0]     rf_wa;
   logic [DW-1:0]     rf_wd;
   logic [AW-1:0]     hz_raA, hz_raB;
   logic              hz_hitA, hz_hitB;
   logic [2:0]        grant_id;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int            m_ptr;
   bit            m_wen;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;
   int            m_gid;
   logic [DW-1:0] m_rf [32];
   logic [DW-1:0] tb_rf [32];

   regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready),
      .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .hz_raA(hz_raA), .hz_raB(hz_raB), .hz_hitA(hz_hitA), .hz_hitB(hz_hitB),
      .grant_id(grant_id)
   );

   always #5 clock = ~clock;

   // shadow regfile capturing on the negedge, like the real one
   always @(negedge clock) begin
      if (rf_wen === 1'b1) tb_rf[rf_wa] <= rf_wd;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = v;
      req_addr[AW*i +: AW] = a;
      req_data[DW*i +: DW] = d;
   endtask

   function automatic int exp_grant();
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   function automatic bit hz_exp(input logic [AW-1:0] a);
      bit r = m_wen && (m_wa == a);
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_addr[AW*i +: AW] == a) r = 1'b1;
      if (SQUASH && a == 0) r = 1'b0;
      return r;
   endfunction

   // Called at posedge+1 with inputs set; returns at the following posedge+1.
   task automatic cycle(output int g);
      logic [N-1:0]  er;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      #3;
      g  = exp_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", req_ready, er);
      check("hz_hitA", hz_hitA, hz_exp(hz_raA));
      check("hz_hitB", hz_hitB, hz_exp(hz_raB));
      @(posedge clock);
      #1;
      if (g >= 0) begin
         a = req_addr[AW*g +: AW];
         d = req_data[DW*g +: DW];
         m_gid = g;
         m_ptr = (g + 1) % N;
         if (SQUASH && a == 0) m_wen = 1'b0;
         else begin
            m_wen = 1'b1; m_wa = a; m_wd = d; m_rf[a] = d;
         end
         req_valid[g] = 1'b0;
      end else begin
         m_wen = 1'b0;
      end
      check("rf_wen", rf_wen, m_wen);
      check("rf_wa", rf_wa, m_wa);
      check("rf_wd", rf_wd, m_wd);
      check("grant_id", grant_id, m_gid);
   endtask

   initial begin
      int g;
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; tb_rf[i] = '0; end
      m_ptr = 0; m_wen = 0; m_wa = '0; m_wd = '0; m_gid = 0;
      reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      hz_raA = 5'd31; hz_raB = 5'd30;
      #2;
      check("rst_wen", rf_wen, 0);
      check("rst_wa", rf_wa, 0);
      check("rst_wd", rf_wd, 0);
      check("rst_gid", grant_id, 0);
      check("rst_ready", req_ready, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // continuous requesters: grants rotate 0,1,2,0,1,2
      for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(10 + k), 32'h1000 + k);
      for (int k = 0; k < 6; k++) begin
         cycle(g);
         check("rr_gid", grant_id, k % 3);
         check("rr_wen", rf_wen, 1);
         set_req(g, 1'b1, 5'(10 + g), 32'h2000 + k);
      end
      req_valid = '0;
      cycle(g);

      // single write from requester 1
      set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
      cycle(g);
      check("sw_wa", rf_wa, 7);
      check("sw_wd", rf_wd, 32'hDEADBEEF);
      check("sw_gid", grant_id, 1);

      // same address from two requesters with rr_ptr=2: later grant (req0) persists
      set_req(0, 1'b1, 5'd5, 32'h11);
      set_req(2, 1'b1, 5'd5, 32'h22);
      cycle(g);
      check("coll_first", rf_wd, 32'h22);
      cycle(g);
      check("coll_second", rf_wd, 32'h11);
      cycle(g);
      check("coll_r5", tb_rf[5], 32'h11);

      // hazard on pending then in-flight write, then clear
      hz_raA = 5'd9; hz_raB = 5'd3;
      set_req(1, 1'b1, 5'd9, 32'h99);
      cycle(g);
      cycle(g);
      cycle(g);
      check("hz_clear", hz_hitA, 0);

      // address-0 write
      hz_raA = 5'd0;
      set_req(0, 1'b1, 5'd0, 32'h55);
      cycle(g);
      check("z_gid", grant_id, 0);
      check("z_wen", rf_wen, SQUASH ? 0 : 1);
      cycle(g);

      // reset while a write is in flight and requests are pending
      hz_raA = 5'd31;
      set_req(1, 1'b1, 5'd12, 32'hCAFE);
      cycle(g);
      set_req(0, 1'b1, 5'd13, 32'hA0A0);
      set_req(2, 1'b1, 5'd14, 32'hB0B0);
      #2;
      reset = 1'b1;
      #1;
      check("mrst_wen", rf_wen, 0);
      check("mrst_wa", rf_wa, 0);
      check("mrst_wd", rf_wd, 0);
      check("mrst_ready", req_ready, 3'b001);
      m_ptr = 0; m_wen = 0; m_wa = '0; m_wd = '0; m_gid = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      cycle(g);
      check("mrst_first", grant_id, 0);
      cycle(g);

      // random traffic
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(1, 0) == 1)
               set_req(i, 1'b1, 5'($urandom_range(31, 0)), $urandom);
         hz_raA = 5'($urandom_range(31, 0));
         hz_raB = 5'($urandom_range(31, 0));
         cycle(g);
      end
      req_valid = '0;
      cycle(g);
      cycle(g);
      for (int i = 0; i < 32; i++) check("regfile", tb_rf[i], m_rf[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
